// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic MAC array sequencer.
// Contents:
//   state_e    - sequencer FSM states
//   calc_kw    - width of k_len for a given K_MAX
//   calc_aw    - operand buffer address width for a given K_MAX
//   calc_fw    - feed counter width, must hold K_MAX+N-2
//   calc_pw    - drain/output phase counter width
//   drain_len  - number of drain cycles (N + DRAIN_EXTRA)
package systolic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StDrain,
    StOut,
    StDone
  } state_e;

  function automatic int unsigned calc_kw(int unsigned k_max);
    return $clog2(k_max + 1);
  endfunction

  function automatic int unsigned calc_aw(int unsigned k_max);
    return (k_max > 1) ? $clog2(k_max) : 1;
  endfunction

  function automatic int unsigned calc_fw(int unsigned n, int unsigned k_max);
    int unsigned w;
    w = $clog2(k_max + n - 1);
    return (w > 0) ? w : 1;
  endfunction

  function automatic int unsigned drain_len(int unsigned n, int unsigned extra);
    return n + extra;
  endfunction

  // Phase counter covers both DRAIN and OUT; DRAIN is never shorter than OUT.
  function automatic int unsigned calc_pw(int unsigned n, int unsigned extra);
    int unsigned w;
    w = $clog2(drain_len(n, extra));
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Skewed operand-read generator for the systolic array.
// Row i (and the matching column) is fed k_reg consecutive operands starting
// i cycles after the first feed cycle.
// Ports:
//   clk, reset - clock, asynchronous active-low reset
//   feed_en    - next cycle is a FEED cycle
//   feed_cnt   - feed counter value for the next cycle
//   k_reg      - latched reduction depth
//   row_en     - registered per-row operand valid
//   rd_addr    - registered packed per-row read address (slice i = row i)
module systolic_skew_gen
  import systolic_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned KW = 7,
  parameter int unsigned AW = 6,
  parameter int unsigned FW = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            feed_en,
  input  logic [FW-1:0]   feed_cnt,
  input  logic [KW-1:0]   k_reg,
  output logic [N-1:0]    row_en,
  output logic [N*AW-1:0] rd_addr
);

  // One spare bit so feed_cnt - i going negative shows up in the MSB.
  localparam int unsigned EW = ((FW > KW) ? FW : KW) + 1;

  logic [N-1:0]    row_en_d;
  logic [N*AW-1:0] rd_addr_d;
  logic [EW-1:0]   cnt_w;

  assign cnt_w = EW'(feed_cnt);

  for (genvar i = 0; i < N; i++) begin : g_row
    localparam logic [EW-1:0] Idx = EW'(i);
    logic [EW-1:0] diff;
    logic          hit;

    // i <= feed_cnt <= i+k_reg-1  <=>  0 <= feed_cnt-i < k_reg
    assign diff = cnt_w - Idx;
    assign hit  = feed_en && !diff[EW-1] && (diff < EW'(k_reg));

    assign row_en_d[i]          = hit;
    assign rd_addr_d[i*AW +: AW] = hit ? AW'(diff) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_en  <= '0;
      rd_addr <= '0;
    end else begin
      row_en  <= row_en_d;
      rd_addr <= rd_addr_d;
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the N x N systolic MAC array.
// Start -> clear accumulators -> skewed feed for k_len steps -> drain ->
// row-by-row result capture -> done pulse. All outputs are registered and
// decoded from the next state so they line up with their state cycle.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   start       - request a multiply (IDLE only); k_len latched on accept
//   k_len       - reduction depth, valid range 1..K_MAX
//   abort       - synchronous abort, returns to IDLE silently
//   busy        - high in every state except IDLE
//   arr_clr     - accumulator clear (CLEAR state)
//   arr_en      - MAC enable (FEED and DRAIN)
//   row_en      - per-row/column operand valid
//   rd_addr     - packed per-row operand address
//   res_valid   - result row capture strobe
//   res_row     - row being captured
//   done        - one-cycle completion pulse
//   err         - one-cycle pulse with done when k_len is out of range
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned K_MAX       = 64,
  parameter int unsigned DRAIN_EXTRA = 0,
  parameter int unsigned KW          = calc_kw(K_MAX),
  parameter int unsigned AW          = calc_aw(K_MAX),
  localparam int unsigned RW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            abort,
  output logic            busy,
  output logic            arr_clr,
  output logic            arr_en,
  output logic [N-1:0]    row_en,
  output logic [N*AW-1:0] rd_addr,
  output logic            res_valid,
  output logic [RW-1:0]   res_row,
  output logic            done,
  output logic            err
);

  localparam int unsigned FW = calc_fw(N, K_MAX);
  localparam int unsigned PW = calc_pw(N, DRAIN_EXTRA);
  localparam int unsigned DL = drain_len(N, DRAIN_EXTRA);

  state_e        state_q, state_d;
  logic [KW-1:0] k_reg_q, k_reg_d;
  logic [FW-1:0] feed_cnt_q, feed_cnt_d;
  logic [PW-1:0] ph_cnt_q, ph_cnt_d;
  logic          err_d;
  logic          k_ok;
  logic          feed_last;

  assign k_ok      = (k_len != '0) && (k_len <= KW'(K_MAX));
  // Modular arithmetic keeps this correct even when FW is narrower than KW.
  assign feed_last = (feed_cnt_q == FW'(k_reg_q) + FW'(N) - FW'(2));

  always_comb begin
    state_d    = state_q;
    k_reg_d    = k_reg_q;
    feed_cnt_d = feed_cnt_q;
    ph_cnt_d   = ph_cnt_q;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // abort wins over start even in IDLE
        if (start && !abort) begin
          k_reg_d = k_len;
          if (k_ok) begin
            state_d = StClear;
          end else begin
            state_d = StDone;
            err_d   = 1'b1;
          end
        end
      end
      StClear: begin
        state_d    = StFeed;
        feed_cnt_d = '0;
      end
      StFeed: begin
        if (feed_last) begin
          state_d  = StDrain;
          ph_cnt_d = '0;
        end else begin
          feed_cnt_d = feed_cnt_q + FW'(1);
        end
      end
      StDrain: begin
        if (ph_cnt_q == PW'(DL - 1)) begin
          state_d  = StOut;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + PW'(1);
        end
      end
      StOut: begin
        if (ph_cnt_q == PW'(N - 1)) begin
          state_d  = StDone;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + PW'(1);
        end
      end
      StDone: begin
        state_d    = StIdle;
        feed_cnt_d = '0;
      end
      default: state_d = StIdle;
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d    = StIdle;
      feed_cnt_d = '0;
      ph_cnt_d   = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      k_reg_q    <= '0;
      feed_cnt_q <= '0;
      ph_cnt_q   <= '0;
      busy       <= 1'b0;
      arr_clr    <= 1'b0;
      arr_en     <= 1'b0;
      res_valid  <= 1'b0;
      res_row    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_reg_q    <= k_reg_d;
      feed_cnt_q <= feed_cnt_d;
      ph_cnt_q   <= ph_cnt_d;
      busy       <= (state_d != StIdle);
      arr_clr    <= (state_d == StClear);
      arr_en     <= (state_d == StFeed) || (state_d == StDrain);
      res_valid  <= (state_d == StOut);
      res_row    <= (state_d == StOut) ? ph_cnt_d[RW-1:0] : '0;
      done       <= (state_d == StDone);
      err        <= err_d;
    end
  end

  // k_reg_q is already loaded by the time CLEAR hands over to FEED.
  systolic_skew_gen #(
    .N  (N),
    .KW (KW),
    .AW (AW),
    .FW (FW)
  ) u_skew_gen (
    .clk      (clk),
    .reset    (reset),
    .feed_en  (state_d == StFeed),
    .feed_cnt (feed_cnt_d),
    .k_reg    (k_reg_q),
    .row_en   (row_en),
    .rd_addr  (rd_addr)
  );

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl: each run pushes the expected
// clear/feed/result/done events; a negedge monitor pops and compares them.
module tb_systolic_seq_ctrl;

  localparam int N     = 4;
  localparam int K_MAX = 64;
  localparam int DE    = 0;
  localparam int KW    = 7;
  localparam int AW    = 6;
  localparam int RW    = 2;
  localparam int DL    = N + DE;
  localparam int BIG   = 1000000;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            busy, arr_clr, arr_en, res_valid, done, err;
  logic [N-1:0]    row_en;
  logic [N*AW-1:0] rd_addr;
  logic [RW-1:0]   res_row;

  systolic_seq_ctrl #(
    .N           (N),
    .K_MAX       (K_MAX),
    .DRAIN_EXTRA (DE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .k_len     (k_len),
    .abort     (abort),
    .busy      (busy),
    .arr_clr   (arr_clr),
    .arr_en    (arr_en),
    .row_en    (row_en),
    .rd_addr   (rd_addr),
    .res_valid (res_valid),
    .res_row   (res_row),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EvClr, EvFeed, EvRes, EvDone} ev_kind_e;
  typedef struct {
    ev_kind_e        kind;
    int              cyc;
    logic [N-1:0]    row_en;
    logic [N*AW-1:0] addr;
    int              row;
    bit              err;
    bit              en;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  busy_cnt = 0;
  int  arr_en_cnt = 0;
  int  done_cnt = 0;

  task automatic chk(input bit ok, input string name, input string act, input string req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %s, expected %s", name, act, req);
    end
  endtask

  function automatic string ev_str(input ev_t e);
    return $sformatf("kind=%0d cyc=%0d row_en=%b addr=%h row=%0d err=%0b arr_en=%0b",
                     e.kind, e.cyc, e.row_en, e.addr, e.row, e.err, e.en);
  endfunction

  task automatic check_ev(input ev_kind_e kind);
    ev_t a, e;
    a.kind = kind; a.cyc = cyc; a.row_en = row_en; a.addr = rd_addr;
    a.row = int'(res_row); a.err = err; a.en = arr_en;
    if (exp_q.size() == 0) begin
      chk(1'b0, "unexpected_event", ev_str(a), "no event");
    end else begin
      e = exp_q.pop_front();
      chk(a.kind == e.kind && a.cyc == e.cyc && a.row_en == e.row_en && a.addr == e.addr &&
          a.row == e.row && a.err == e.err && a.en == e.en, "event", ev_str(a), ev_str(e));
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    busy_cnt   += int'(busy);
    arr_en_cnt += int'(arr_en);
    if (arr_clr) check_ev(EvClr);
    if (row_en != '0) check_ev(EvFeed);
    if (res_valid) check_ev(EvRes);
    if (done) begin
      done_cnt++;
      check_ev(EvDone);
    end
    if (err && !done) chk(1'b0, "err_without_done", "err=1 done=0", "err only with done");
  end

  function automatic void push(input ev_kind_e k, input int c, input logic [N-1:0] re,
                               input logic [N*AW-1:0] ad, input int row, input bit er,
                               input bit en);
    ev_t e;
    e.kind = k; e.cyc = c; e.row_en = re; e.addr = ad; e.row = row; e.err = er; e.en = en;
    exp_q.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string name);
    logic [N*AW+N+RW+7-1:0] v;
    v = {busy, arr_clr, arr_en, row_en, rd_addr, res_valid, res_row, done, err};
    chk(v == '0, name, $sformatf("%h", v), "all zero");
  endtask

  // abort_at / reset_at / restart_at are cycles relative to the start cycle; 0 = unused.
  task automatic run_op(input int k, input int abort_at, input int reset_at,
                        input int restart_at, input int restart_k);
    int t0, cut, d0, exp_done, limit, exp_busy, exp_en;
    bit valid, got;
    logic [N-1:0]    re;
    logic [N*AW-1:0] ad;
    valid = (k >= 1) && (k <= K_MAX);
    step();
    t0 = cyc;
    d0 = done_cnt;
    busy_cnt = 0;
    arr_en_cnt = 0;
    k_len = KW'(k);
    start = 1'b1;
    cut = (abort_at > 0) ? abort_at + 1 : (reset_at > 0) ? reset_at : BIG;
    exp_done = valid ? 2 + (k + N - 1) + DL + N : 1;

    if (valid) begin
      if (1 < cut) push(EvClr, t0 + 1, '0, '0, 0, 1'b0, 1'b0);
      for (int f = 0; f <= k + N - 2; f++) begin
        re = '0;
        ad = '0;
        for (int i = 0; i < N; i++) begin
          if (f >= i && f <= i + k - 1) begin
            re[i] = 1'b1;
            ad[i*AW +: AW] = AW'(f - i);
          end
        end
        if (2 + f < cut) push(EvFeed, t0 + 2 + f, re, ad, 0, 1'b0, 1'b1);
      end
      for (int r = 0; r < N; r++) begin
        if (2 + (k + N - 1) + DL + r < cut)
          push(EvRes, t0 + 2 + (k + N - 1) + DL + r, '0, '0, r, 1'b0, 1'b0);
      end
      if (cut == BIG) push(EvDone, t0 + exp_done, '0, '0, 0, 1'b0, 1'b0);
    end else begin
      push(EvDone, t0 + 1, '0, '0, 0, 1'b1, 1'b0);
    end

    limit = (cut < BIG) ? cut + 10 : exp_done + 10;
    got = 1'b0;
    for (int r = 1; r <= limit; r++) begin
      step();
      start = 1'b0;
      abort = 1'b0;
      if (r == restart_at) begin
        start = 1'b1;
        k_len = KW'(restart_k);
      end
      if (r == abort_at) abort = 1'b1;
      if (abort_at > 0 && r == abort_at + 1) chk_zero("abort_outputs_zero");
      if (r == reset_at) begin
        #1 reset = 1'b0;
        #1 chk_zero("reset_outputs_zero");
      end
      if (reset_at > 0 && r == reset_at + 2) reset = 1'b1;
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;

    if (cut == BIG) begin
      chk(got, "done_seen", $sformatf("%0b", got), "1");
      chk(busy == 1'b0, "busy_after_done", $sformatf("%0b", busy), "0");
      exp_busy = exp_done;
      exp_en = valid ? (k + N - 1) + DL : 0;
    end else begin
      chk(done_cnt == d0, "no_done", $sformatf("%0d", done_cnt - d0), "0");
      exp_busy = cut - 1;
      exp_en = cut - 2;
    end
    chk(busy_cnt == exp_busy, "busy_cycles", $sformatf("%0d", busy_cnt),
        $sformatf("%0d", exp_busy));
    chk(arr_en_cnt == exp_en, "arr_en_cycles", $sformatf("%0d", arr_en_cnt),
        $sformatf("%0d", exp_en));
    chk(exp_q.size() == 0, "queue_drained", $sformatf("%0d left", exp_q.size()), "0 left");
    exp_q.delete();
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #2;
    chk_zero("reset_state");
    reset = 1'b1;
    step();

    run_op(4, 0, 0, 0, 0);      // nominal
    run_op(1, 0, 0, 0, 0);      // k=1 single-pulse rows
    run_op(0, 0, 0, 0, 0);      // k=0 -> err
    run_op(65, 0, 0, 0, 0);     // k>K_MAX -> err
    run_op(5, 0, 0, 6, 9);      // start mid-run ignored
    run_op(3, 0, 0, 0, 0);      // next start accepted
    run_op(4, 4, 0, 0, 0);      // abort in FEED
    run_op(4, 0, 0, 0, 0);
    run_op(4, 0, 10, 0, 0);     // async reset in DRAIN
    run_op(4, 0, 0, 0, 0);
    run_op(K_MAX, 0, 0, 0, 0);  // deepest reduction

    // abort and start together in IDLE: start must not be taken
    step();
    d0 = done_cnt;
    busy_cnt = 0;
    k_len = KW'(4);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    repeat (6) step();
    chk(busy_cnt == 0, "abort_blocks_start", $sformatf("%0d", busy_cnt), "0");
    chk(done_cnt == d0, "abort_blocks_done", $sformatf("%0d", done_cnt - d0), "0");
    run_op(2, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
